gps_channel_scheduler: RTL and testbench

Configuration controller for the multi-satellite GPS emulator datapath. Accepts host writes of per-satellite Doppler frequency, gain and C/A code select, plus the global noise gain, into a shadow bank. On commit, it transfers the whole bank atomically to the active outputs that drive the emulator. The transfer happens at the next 1 ms code-epoch boundary, so no satellite changes parameters mid-epoch. It also sequences the emulator enable from a run request.

---
 rtl/gps_channel_scheduler.sv | 129 ++++++++++++
 tb/tb_gps_channel_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gps_channel_scheduler.sv
// GPS emulator configuration controller: host writes land in a shadow bank that is
// committed atomically to the active outputs on a code-epoch boundary.
module gps_channel_scheduler #(
    parameter int NSAT      = 4,
    parameter int EPOCH_LEN = 4000,
    parameter int SAT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_field,
    input  logic [SAT_W-1:0]     cfg_sat,
    input  logic [31:0]          cfg_data,
    input  logic                 commit,
    output logic                 cfg_err,
    output logic                 commit_done,
    output logic                 epoch_tick,
    output logic                 enable,
    output logic [32*NSAT-1:0]   freq,
    output logic [16*NSAT-1:0]   gain,
    output logic [6*NSAT-1:0]    ca_sel,
    output logic [15:0]          noise_gain
);
    localparam int CNT_W = $clog2(EPOCH_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(EPOCH_LEN - 1);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [NSAT-1:0][31:0]   r_sh_freq, r_freq;
    logic [NSAT-1:0][15:0]   r_sh_gain, r_gain;
    logic [NSAT-1:0][5:0]    r_sh_ca, r_ca;
    logic [15:0]             r_sh_noise, r_noise;

    logic                    w_accept;
    logic                    w_sat_ok;
    logic                    w_bad;
    logic                    w_apply;
    logic [CNT_W-1:0]        w_cnt_nxt;

    assign w_accept  = cfg_valid & cfg_ready;
    assign w_sat_ok  = (32'(cfg_sat) < NSAT);
    assign w_bad     = (cfg_field != 2'd3) &&
                       (!w_sat_ok || ((cfg_field == 2'd2) && (cfg_data[5:0] > 6'd35)));
    // Pending commit lands at the end of the tick cycle, or at once if the emulator is stopped.
    assign w_apply   = (r_state == S_PENDING) && (!run || epoch_tick);
    // Count only once enable has followed run, so the first epoch starts at 0 on the rising edge.
    assign w_cnt_nxt = (run && enable) ? ((r_cnt == LAST) ? '0 : r_cnt + 1'b1) : '0;

    assign freq       = r_freq;
    assign gain       = r_gain;
    assign ca_sel     = r_ca;
    assign noise_gain = r_noise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            enable     <= 1'b0;
            epoch_tick <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            enable     <= run;
            epoch_tick <= (w_cnt_nxt == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            cfg_ready   <= 1'b0;
            cfg_err     <= 1'b0;
            commit_done <= 1'b0;
            r_sh_noise  <= '0;
            r_noise     <= '0;
            for (int i = 0; i < NSAT; i++) begin
                r_sh_freq[i] <= '0;
                r_freq[i]    <= '0;
                r_sh_gain[i] <= '0;
                r_gain[i]    <= '0;
                r_sh_ca[i]   <= 6'(i);
                r_ca[i]      <= 6'(i);
            end
        end else begin
            cfg_err     <= w_accept && w_bad;
            commit_done <= w_apply;

            if (w_accept && !w_bad) begin
                if (cfg_field == 2'd3) begin
                    r_sh_noise <= cfg_data[15:0];
                end
                for (int i = 0; i < NSAT; i++) begin
                    if (32'(cfg_sat) == i) begin
                        case (cfg_field)
                            2'd0:    r_sh_freq[i] <= cfg_data;
                            2'd1:    r_sh_gain[i] <= cfg_data[15:0];
                            2'd2:    r_sh_ca[i]   <= cfg_data[5:0];
                            default: ;
                        endcase
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (commit) begin
                        r_state   <= S_PENDING;
                        cfg_ready <= 1'b0;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end
                S_PENDING: begin
                    if (w_apply) begin
                        r_state   <= S_IDLE;
                        cfg_ready <= 1'b1;
                        r_freq    <= r_sh_freq;
                        r_gain    <= r_sh_gain;
                        r_ca      <= r_sh_ca;
                        r_noise   <= r_sh_noise;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gps_channel_scheduler.sv
// Directed testbench for gps_channel_scheduler with a short epoch (EPOCH_LEN=8).
module tb_gps_channel_scheduler;
    localparam int NSAT = 4;
    localparam int EPOCH_LEN = 8;
    localparam int SAT_W = 3;
    localparam logic [23:0] CA_RST = {6'd3, 6'd2, 6'd1, 6'd0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_field;
    logic [SAT_W-1:0] cfg_sat;
    logic [31:0] cfg_data;
    logic        commit;
    logic        cfg_err;
    logic        commit_done;
    logic        epoch_tick;
    logic        enable;
    logic [32*NSAT-1:0] freq;
    logic [16*NSAT-1:0] gain;
    logic [6*NSAT-1:0]  ca_sel;
    logic [15:0] noise_gain;

    int errors = 0;
    int checks = 0;

    gps_channel_scheduler #(.NSAT(NSAT), .EPOCH_LEN(EPOCH_LEN), .SAT_W(SAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_field(cfg_field),
        .cfg_sat(cfg_sat), .cfg_data(cfg_data), .commit(commit),
        .cfg_err(cfg_err), .commit_done(commit_done), .epoch_tick(epoch_tick),
        .enable(enable), .freq(freq), .gain(gain), .ca_sel(ca_sel),
        .noise_gain(noise_gain)
    );

    always #5 clk = ~clk;

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] f, input logic [SAT_W-1:0] s, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_field = f;
        cfg_sat   = s;
        cfg_data  = d;
        tick_clk();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_clk();
        tick_clk();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", cfg_ready); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%0b exp=0", enable); end
        checks++; if (freq !== '0) begin errors++; $display("FAIL reset_freq got=%0h exp=0", freq); end
        checks++; if (gain !== '0) begin errors++; $display("FAIL reset_gain got=%0h exp=0", gain); end
        checks++; if (ca_sel !== CA_RST) begin errors++; $display("FAIL reset_ca got=%0h exp=%0h", ca_sel, CA_RST); end
        checks++; if (noise_gain !== 16'h0) begin errors++; $display("FAIL reset_noise got=%0h exp=0", noise_gain); end
        checks++; if ({cfg_err, commit_done, epoch_tick} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%0b exp=000", {cfg_err, commit_done, epoch_tick}); end
        rst_n = 1'b1;
        tick_clk();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%0b exp=1", cfg_ready); end
    endtask

    task automatic test_reject();
        do_write(2'd0, 3'd5, 32'd123);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_bad_sat got=%0b exp=1", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_bad got=%0b exp=1", cfg_ready); end
        tick_clk();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len got=%0b exp=0", cfg_err); end
        do_write(2'd2, 3'd0, 32'd40);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_bad_ca got=%0b exp=1", cfg_err); end
        tick_clk();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len2 got=%0b exp=0", cfg_err); end
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        tick_clk();
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL rej_commit_done got=%0b exp=1", commit_done); end
        checks++; if (ca_sel !== CA_RST) begin errors++; $display("FAIL rej_ca got=%0h exp=%0h", ca_sel, CA_RST); end
        checks++; if (freq !== '0) begin errors++; $display("FAIL rej_freq got=%0h exp=0", freq); end
        tick_clk();
    endtask

    task automatic test_run0_commit();
        do_write(2'd2, 3'd1, 32'd20);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL good_ca_err got=%0b exp=0", cfg_err); end
        checks++; if (ca_sel !== CA_RST) begin errors++; $display("FAIL ca_before_commit got=%0h exp=%0h", ca_sel, CA_RST); end
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_ready got=%0b exp=0", cfg_ready); end
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL early_done got=%0b exp=0", commit_done); end
        tick_clk();
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL run0_done got=%0b exp=1", commit_done); end
        checks++; if (ca_sel !== {6'd3, 6'd2, 6'd20, 6'd0}) begin errors++; $display("FAIL run0_ca got=%0h exp=%0h", ca_sel, {6'd3, 6'd2, 6'd20, 6'd0}); end
        tick_clk();
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL run0_done_len got=%0b exp=0", commit_done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL run0_ready got=%0b exp=1", cfg_ready); end
    endtask

    task automatic test_epoch_commit();
        run = 1'b1;
        tick_clk();
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL run_enable got=%0b exp=1", enable); end
        do_write(2'd0, 3'd0, 32'd536871);
        do_write(2'd1, 3'd0, 32'h1000);
        commit = 1'b1;
        do_write(2'd3, 3'd0, 32'h4000);
        commit = 1'b0;
        for (int c = 3; c < 8; c++) begin
            checks++; if (freq[31:0] !== 32'd0 || noise_gain !== 16'h0 || commit_done !== 1'b0) begin
                errors++; $display("FAIL hold_cnt%0d freq=%0h noise=%0h done=%0b exp=0,0,0", c, freq[31:0], noise_gain, commit_done);
            end
            checks++; if (epoch_tick !== (c == 7)) begin errors++; $display("FAIL tick_cnt%0d got=%0b exp=%0b", c, epoch_tick, (c == 7)); end
            tick_clk();
        end
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL epoch_done got=%0b exp=1", commit_done); end
        checks++; if (freq[31:0] !== 32'd536871) begin errors++; $display("FAIL epoch_freq0 got=%0d exp=536871", freq[31:0]); end
        checks++; if (gain[15:0] !== 16'h1000) begin errors++; $display("FAIL epoch_gain0 got=%0h exp=1000", gain[15:0]); end
        checks++; if (noise_gain !== 16'h4000) begin errors++; $display("FAIL epoch_noise got=%0h exp=4000", noise_gain); end
        tick_clk();
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL epoch_done_len got=%0b exp=0", commit_done); end
    endtask

    task automatic test_tick_commit();
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (epoch_tick) found = 1'b1;
            else tick_clk();
        end
        checks++; if (!found) begin errors++; $display("FAIL tick_wait got=timeout exp=tick"); end
        commit = 1'b1;
        do_write(2'd0, 3'd2, 32'h55);
        commit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (commit_done !== 1'b0 || cfg_ready !== 1'b0) begin
                errors++; $display("FAIL tick_pend%0d done=%0b ready=%0b exp=0,0", i, commit_done, cfg_ready);
            end
            if (i == 2) begin
                commit = 1'b1; cfg_valid = 1'b1; cfg_field = 2'd1; cfg_sat = 3'd3; cfg_data = 32'h7777;
            end else begin
                commit = 1'b0; cfg_valid = 1'b0;
            end
            tick_clk();
        end
        checks++; if (commit_done !== 1'b1) begin errors++; $display("FAIL tick_done got=%0b exp=1", commit_done); end
        checks++; if (freq[95:64] !== 32'h55) begin errors++; $display("FAIL tick_freq2 got=%0h exp=55", freq[95:64]); end
        checks++; if (gain[63:48] !== 16'h0) begin errors++; $display("FAIL ignored_write got=%0h exp=0", gain[63:48]); end
        tick_clk();
        checks++; if (commit_done !== 1'b0) begin errors++; $display("FAIL second_commit got=%0b exp=0", commit_done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL tick_ready got=%0b exp=1", cfg_ready); end
    endtask

    task automatic test_run_toggle();
        run = 1'b0;
        tick_clk();
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL en_fall got=%0b exp=0", enable); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (epoch_tick !== 1'b0) begin errors++; $display("FAIL tick_run0_%0d got=%0b exp=0", i, epoch_tick); end
            tick_clk();
        end
        run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick_clk();
            checks++; if (enable !== 1'b1) begin errors++; $display("FAIL en_rise%0d got=%0b exp=1", i, enable); end
            checks++; if (epoch_tick !== (i == 8)) begin errors++; $display("FAIL first_tick%0d got=%0b exp=%0b", i, epoch_tick, (i == 8)); end
        end
        run = 1'b0;
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL en_lag got=%0b exp=1", enable); end
        tick_clk();
        checks++; if (enable !== 1'b0 || epoch_tick !== 1'b0) begin errors++; $display("FAIL en_off en=%0b tick=%0b exp=0,0", enable, epoch_tick); end
        run = 1'b1;
        tick_clk();
        run = 1'b0;
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL en_pulse got=%0b exp=1", enable); end
        tick_clk();
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL en_pulse_end got=%0b exp=0", enable); end
    endtask

    task automatic test_reset_pending();
        run = 1'b1;
        tick_clk();
        do_write(2'd0, 3'd1, 32'h999);
        commit = 1'b1;
        tick_clk();
        commit = 1'b0;
        tick_clk();
        tick_clk();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rp_pending got=%0b exp=0", cfg_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (freq !== '0 || gain !== '0 || noise_gain !== 16'h0) begin
            errors++; $display("FAIL rp_async freq=%0h gain=%0h noise=%0h exp=0", freq, gain, noise_gain);
        end
        checks++; if (ca_sel !== CA_RST) begin errors++; $display("FAIL rp_ca got=%0h exp=%0h", ca_sel, CA_RST); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL rp_enable got=%0b exp=0", enable); end
        tick_clk();
        tick_clk();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick_clk();
            checks++; if (commit_done !== 1'b0 || freq !== '0) begin
                errors++; $display("FAIL rp_after%0d done=%0b freq=%0h exp=0,0", i, commit_done, freq);
            end
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rp_ready got=%0b exp=1", cfg_ready); end
        run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_field = 2'd0;
        cfg_sat = '0; cfg_data = 32'd0; commit = 1'b0;
        test_reset();
        test_reject();
        test_run0_commit();
        test_epoch_commit();
        test_tick_commit();
        test_run_toggle();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
